// File: rtl/qtree_run_ctrl.sv
// Run sequencer between the QTree AXI-stream loader and the dataflow kernel:
// gates heap writes, collects argument root pointers, launches tokens, captures the result.
module qtree_run_ctrl #(
  parameter int unsigned N_ARGS = 4,
  parameter int unsigned PTR_W  = 16,
  parameter int unsigned RES_W  = 32,
  parameter int unsigned TMO_W  = 20
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    err_clr,
  input  logic                    ld_tvalid,
  input  logic                    ld_tlast,
  output logic                    ld_tready,
  input  logic                    heap_wr_ready,
  output logic                    heap_wr_valid,
  input  logic                    wptr_valid,
  input  logic [PTR_W-1:0]        wptr_data,
  output logic                    go_valid,
  input  logic                    go_ready,
  output logic [N_ARGS-1:0]       arg_valid,
  input  logic [N_ARGS-1:0]       arg_ready,
  output logic [N_ARGS*PTR_W-1:0] arg_data,
  input  logic                    res_valid,
  input  logic [RES_W-1:0]        res_data,
  output logic                    res_ready,
  output logic [RES_W-1:0]        result_data,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    error,
  output logic [15:0]             run_count
);

  localparam int unsigned IDX_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(N_ARGS - 1);
  localparam logic [TMO_W-1:0] TmoLast = {TMO_W{1'b1}} - 1'b1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StLaunch = 3'd2;
  localparam logic [2:0] StWait   = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;
  localparam logic [2:0] StErr    = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wait_ptr_q, wait_ptr_d;
  logic                    last_pend_q, last_pend_d;
  logic [N_ARGS*PTR_W-1:0] arg_data_q, arg_data_d;
  logic                    go_valid_q, go_valid_d;
  logic                    go_done_q, go_done_d;
  logic [N_ARGS-1:0]       arg_valid_q, arg_valid_d;
  logic [N_ARGS-1:0]       arg_done_q, arg_done_d;
  logic                    res_ready_q, res_ready_d;
  logic [RES_W-1:0]        result_data_q, result_data_d;
  logic                    result_valid_q, result_valid_d;
  logic [15:0]             run_count_q, run_count_d;
  logic [TMO_W-1:0]        wdog_q, wdog_d;

  logic in_load, beat_acc, ptr_ret, wdog_run, wdog_tmo;

  // Ready uses the registered wait_ptr, so a beat can never overlap a pointer return.
  assign in_load       = (state_q == StLoad);
  assign ld_tready     = in_load & heap_wr_ready & ~wait_ptr_q;
  assign heap_wr_valid = in_load & ld_tvalid & ~wait_ptr_q;
  assign beat_acc      = ld_tvalid & ld_tready;
  assign ptr_ret       = in_load & wait_ptr_q & wptr_valid;
  assign wdog_run      = (in_load & wait_ptr_q) | (state_q == StLaunch) | (state_q == StWait);
  assign wdog_tmo      = wdog_run & (wdog_q == TmoLast);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wait_ptr_d     = wait_ptr_q;
    last_pend_d    = last_pend_q;
    arg_data_d     = arg_data_q;
    go_valid_d     = go_valid_q;
    go_done_d      = go_done_q;
    arg_valid_d    = arg_valid_q;
    arg_done_d     = arg_done_q;
    res_ready_d    = res_ready_q;
    result_data_d  = result_data_q;
    result_valid_d = result_valid_q;
    run_count_d    = run_count_q;
    wdog_d         = wdog_run ? wdog_q + 1'b1 : wdog_q;
    if (ptr_ret) wdog_d = '0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d        = StLoad;
          idx_d          = '0;
          wait_ptr_d     = 1'b0;
          go_done_d      = 1'b0;
          arg_done_d     = '0;
          result_valid_d = 1'b0;
        end
      end
      StLoad: begin
        if (beat_acc) begin
          wait_ptr_d  = 1'b1;
          last_pend_d = ld_tlast;
        end
        if (ptr_ret) begin
          wait_ptr_d = 1'b0;
          if (last_pend_q) begin
            arg_data_d[idx_q*PTR_W +: PTR_W] = wptr_data;
            idx_d = idx_q + 1'b1;
            if (idx_q == IdxLast) begin
              state_d     = StLaunch;
              go_valid_d  = 1'b1;
              arg_valid_d = '1;
            end
          end
        end else if (wdog_tmo) begin
          state_d    = StErr;
          wait_ptr_d = 1'b0;
        end
      end
      StLaunch: begin
        if (go_valid_q & go_ready) begin
          go_valid_d = 1'b0;
          go_done_d  = 1'b1;
        end
        for (int unsigned i = 0; i < N_ARGS; i++) begin
          if (arg_valid_q[i] & arg_ready[i]) begin
            arg_valid_d[i] = 1'b0;
            arg_done_d[i]  = 1'b1;
          end
        end
        if (go_done_d & (&arg_done_d)) begin
          state_d     = StWait;
          res_ready_d = 1'b1;
        end else if (wdog_tmo) begin
          state_d     = StErr;
          go_valid_d  = 1'b0;
          arg_valid_d = '0;
        end
      end
      StWait: begin
        if (res_valid) begin
          state_d        = StDone;
          result_data_d  = res_data;
          result_valid_d = 1'b1;
          res_ready_d    = 1'b0;
          run_count_d    = run_count_q + 16'd1;
        end else if (wdog_tmo) begin
          state_d     = StErr;
          res_ready_d = 1'b0;
        end
      end
      StErr: begin
        if (err_clr) begin
          state_d        = StIdle;
          result_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) wdog_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      wait_ptr_q     <= 1'b0;
      last_pend_q    <= 1'b0;
      arg_data_q     <= '0;
      go_valid_q     <= 1'b0;
      go_done_q      <= 1'b0;
      arg_valid_q    <= '0;
      arg_done_q     <= '0;
      res_ready_q    <= 1'b0;
      result_data_q  <= '0;
      result_valid_q <= 1'b0;
      run_count_q    <= '0;
      wdog_q         <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wait_ptr_q     <= wait_ptr_d;
      last_pend_q    <= last_pend_d;
      arg_data_q     <= arg_data_d;
      go_valid_q     <= go_valid_d;
      go_done_q      <= go_done_d;
      arg_valid_q    <= arg_valid_d;
      arg_done_q     <= arg_done_d;
      res_ready_q    <= res_ready_d;
      result_data_q  <= result_data_d;
      result_valid_q <= result_valid_d;
      run_count_q    <= run_count_d;
      wdog_q         <= wdog_d;
    end
  end

  assign go_valid     = go_valid_q;
  assign arg_valid    = arg_valid_q;
  assign arg_data     = arg_data_q;
  assign res_ready    = res_ready_q;
  assign result_data  = result_data_q;
  assign result_valid = result_valid_q;
  assign run_count    = run_count_q;
  assign busy         = (state_q == StLoad) | (state_q == StLaunch) | (state_q == StWait);
  assign error        = (state_q == StErr);

endmodule

// File: doc/qtree_run_ctrl.md
Name: qtree_run_ctrl

Overview:
- Run-sequencing controller between the AXI-stream QTree loader and the generated dataflow kernel.
- Each run has three phases:
  - Load phase: gates loader write beats into the heap and collects the root pointer of each completed tree argument.
  - Launch phase: issues the kernel Go token and all argument pointer tokens.
  - Result phase: captures the kernel result.
- Supports repeated runs and detects a hung kernel or heap with a watchdog.

Parameters:
- N_ARGS, 4, number of QTree pointer arguments per run (2..8).
- PTR_W, 16, pointer payload width (excludes valid bit).
- RES_W, 32, result payload width.
- TMO_W, 20, watchdog counter width; timeout fires at count 2^TMO_W-1.

Ports:
- clk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- start  in  1  one-cycle run request.
- err_clr  in  1  leave ERR state.
- ld_tvalid  in  1  loader beat valid.
- ld_tlast  in  1  beat completes one tree argument.
- ld_tready  out  1  gated ready back to loader.
- heap_wr_ready  in  1  heap write-port ready.
- heap_wr_valid  out  1  gated valid to heap write port.
- wptr_valid  in  1  heap returns pointer of the accepted write.
- wptr_data  in  PTR_W  returned pointer.
- go_valid  out  1  kernel Go token valid.
- go_ready  in  1  kernel Go token ready.
- arg_valid  out  N_ARGS  per-argument pointer token valid.
- arg_ready  in  N_ARGS  per-argument ready.
- arg_data  out  N_ARGS*PTR_W  argument pointers; slot i at [i*PTR_W +: PTR_W].
- res_valid  in  1  kernel result valid.
- res_data  in  RES_W  kernel result.
- res_ready  out  1  result ready.
- result_data  out  RES_W  captured result.
- result_valid  out  1  result held.
- busy  out  1  state not in {IDLE, DONE, ERR}.
- error  out  1  state == ERR.
- run_count  out  16  completed runs, wraps at 65535->0.

Behaviour:
- Clock, reset and state encoding:
  - Single clock clk. Synchronous active-low reset aresetn: sampled on posedge clk; reset is in effect while aresetn==0.
  - Registers are updated only at posedge clk.
  - States: IDLE, LOAD, LAUNCH, WAIT, DONE, ERR.
- Reset values:
  - state=IDLE; all valids/readys out = 0; arg_data=0; result_data=0; result_valid=0; run_count=0; watchdog=0; arg index=0; wait_ptr=0.
  - Reset mid-run aborts the run immediately. Nothing is reissued to the kernel.
- IDLE/DONE:
  - start=1 -> LOAD. Entering LOAD clears the arg index, the launch-done bits and result_valid.
  - start is ignored in LOAD, LAUNCH, WAIT and ERR.
- LOAD:
  - ld_tready = heap_wr_ready & ~wait_ptr; heap_wr_valid = ld_tvalid & ~wait_ptr. Both are combinational and are 0 outside LOAD.
  - Beat accepted (ld_tvalid & ld_tready): set wait_ptr=1 and latch ld_tlast into last_pend. At most one write is outstanding.
  - wptr_valid while wait_ptr=1: clear wait_ptr.
    - If last_pend: slot[idx] <= wptr_data, idx++.
    - If idx==N_ARGS-1 at that point: -> LAUNCH next cycle.
  - wptr_valid while wait_ptr=0 is spurious and ignored.
  - A new beat is accepted no earlier than the cycle after the pointer returns.
- LAUNCH:
  - go_valid and all arg_valid[i] assert together on the first LAUNCH cycle.
  - Each channel deasserts independently the cycle after its own ready is sampled high while valid. Its done bit is set then and it never reasserts within the run.
  - arg_data holds stable throughout the phase.
  - When all N_ARGS+1 done bits are set -> WAIT.
- WAIT:
  - res_ready=1 (registered, asserted from the first WAIT cycle).
  - res_valid=1: result_data<=res_data, result_valid<=1, res_ready<=0, run_count++ -> DONE.
  - result_valid stays high until the next start or reset.
- Watchdog:
  - Counts cycles in which (LOAD & wait_ptr) or LAUNCH or WAIT; clears on any state change or pointer return.
  - Reaching 2^TMO_W-1 -> ERR.
- ERR:
  - All handshake outputs are 0 and error=1.
  - err_clr=1 -> IDLE; result_valid is cleared and run_count is kept.
- Simultaneous events:
  - wptr_valid with a new ld_tvalid in the same cycle: the beat is not accepted that cycle, because ld_tready uses the registered wait_ptr.
  - Timeout and completing handshake in the same cycle: the handshake wins.

Test Plan:
- N_ARGS=4, heap ready always, pointer returned one cycle after each beat. Stream 3 trees of 5 beats and 1 of 1 beat; pointers 0x0004, 0x0009, 0x000E, 0x000F returned on the tlast beats -> arg_data slots = {0x000F,0x000E,0x0009,0x0004}, LAUNCH is entered, and ld_tready never goes high two cycles in a row.
- LAUNCH with arg_ready[2] delayed 7 cycles, others immediate:
  - All valids except arg_valid[2] drop after 1 cycle; arg_valid[2] drops the cycle after its ready.
  - WAIT is entered exactly once, with no token duplicated.
- In WAIT, res_valid with res_data=0x0000_002A -> result_data=0x2A, result_valid=1, run_count=1, DONE. A second start clears result_valid, and a second run yields run_count=2.
- TMO_W=4, res_valid held 0 in WAIT -> ERR after 15 cycles with error=1 and busy=0. err_clr -> IDLE, and start is accepted again.
- Reset asserted mid-LOAD after 2 trees -> next cycle all outputs are at reset values. A new run captures fresh pointers from slot 0.
- start pulsed during LAUNCH and WAIT, and spurious wptr_valid pulsed in LOAD with wait_ptr=0 -> no state or slot changes.
